// File: rtl/cmd_phy_if.sv
// Control-side handshake between the SD command controller (master) and cmd_phy (slave).
interface cmd_phy_if;
   logic         start;
   logic [5:0]   cmd_index;
   logic [31:0]  cmd_argument;
   logic [1:0]   response_type;
   logic         crc_check_en;
   logic         index_check_en;
   logic [127:0] response;
   logic         busy;
   logic         done;
   logic         ack;
   logic         err_timeout;
   logic         err_crc;
   logic         err_end;
   logic         err_index;

   modport master (
      output start, cmd_index, cmd_argument, response_type, crc_check_en, index_check_en, ack,
      input  response, busy, done, err_timeout, err_crc, err_end, err_index
   );

   modport slave (
      input  start, cmd_index, cmd_argument, response_type, crc_check_en, index_check_en, ack,
      output response, busy, done, err_timeout, err_crc, err_end, err_index
   );
endinterface

// File: rtl/cmd_phy.sv
// SD host CMD-line PHY: serialises a 48-bit command with CRC7, turns the line around,
// waits for the card's start bit and deserialises/checks a 48- or 136-bit response.
module cmd_phy #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic     clock,
   input  logic     reset,
   input  logic     sd_clk_en,
   input  logic     cmd_pin_in,
   output logic     cmd_pin_out,
   output logic     cmd_oe,
   cmd_phy_if.slave host
);
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEND,
      S_TURN,
      S_RECV,
      S_DONE
   } state_t;

   state_t state, state_nxt;

   logic [47:0]     tx_sr;
   logic [5:0]      tx_cnt;
   logic [5:0]      idx_q;
   logic [1:0]      type_q;
   logic            crc_en_q;
   logic            idx_en_q;
   logic [TO_W-1:0] to_cnt;
   logic [7:0]      rx_cnt;
   logic [126:0]    rx_sr;
   logic [6:0]      rx_crc;
   logic [127:0]    response_q;
   logic            err_timeout_q, err_crc_q, err_end_q, err_index_q;
   logic            busy_c, done_c;

   logic [39:0]     cmd_body;
   logic [127:0]    rx_nxt;
   logic            accept, is_long, tx_last, to_expire, rx_last, rx_covered;

   function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
      logic fb;
      fb = crc[6] ^ bit_in;
      return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
   endfunction

   function automatic logic [6:0] crc7_of(input logic [39:0] data);
      logic [6:0] crc;
      crc = '0;
      for (int i = 39; i >= 0; i--) crc = crc7_step(crc, data[i]);
      return crc;
   endfunction

   assign cmd_body   = {2'b01, host.cmd_index, host.cmd_argument};
   assign accept     = (state == S_IDLE) && host.start;
   assign is_long    = (type_q == 2'b01);
   assign tx_last    = (tx_cnt == 6'd47);
   assign to_expire  = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
   assign rx_last    = (rx_cnt == (is_long ? 8'd135 : 8'd47));
   // The 136-bit CRC skips the start/transmission/reserved byte; the 48-bit CRC starts at bit 0.
   assign rx_covered = is_long ? (rx_cnt >= 8'd8 && rx_cnt <= 8'd127) : (rx_cnt <= 8'd39);
   assign rx_nxt     = {rx_sr, cmd_pin_in};

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // NOTE: the default assignment up front keeps this combinational block from inferring a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (host.start) state_nxt = S_SEND;
         S_SEND: if (sd_clk_en && tx_last) state_nxt = (type_q == 2'b00) ? S_DONE : S_TURN;
         S_TURN: begin
            if (sd_clk_en) begin
               if (!cmd_pin_in)    state_nxt = S_RECV;
               else if (to_expire) state_nxt = S_DONE;
            end
         end
         S_RECV: if (sd_clk_en && rx_last) state_nxt = S_DONE;
         S_DONE: if (host.ack) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      cmd_oe      = 1'b0;
      cmd_pin_out = 1'b1;
      busy_c      = 1'b0;
      done_c      = 1'b0;
      case (state)
         S_SEND: begin
            cmd_oe      = 1'b1;
            cmd_pin_out = tx_sr[47];
            busy_c      = 1'b1;
         end
         S_TURN, S_RECV: busy_c = 1'b1;
         S_DONE:         done_c = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tx_sr         <= '1;
         tx_cnt        <= '0;
         idx_q         <= '0;
         type_q        <= '0;
         crc_en_q      <= 1'b0;
         idx_en_q      <= 1'b0;
         to_cnt        <= '0;
         rx_cnt        <= '0;
         rx_sr         <= '0;
         rx_crc        <= '0;
         response_q    <= '0;
         err_timeout_q <= 1'b0;
         err_crc_q     <= 1'b0;
         err_end_q     <= 1'b0;
         err_index_q   <= 1'b0;
      end else if (accept) begin
         tx_sr         <= {cmd_body, crc7_of(cmd_body), 1'b1};
         tx_cnt        <= '0;
         idx_q         <= host.cmd_index;
         type_q        <= host.response_type;
         crc_en_q      <= host.crc_check_en;
         idx_en_q      <= host.index_check_en;
         to_cnt        <= '0;
         response_q    <= '0;
         err_timeout_q <= 1'b0;
         err_crc_q     <= 1'b0;
         err_end_q     <= 1'b0;
         err_index_q   <= 1'b0;
      end else if (sd_clk_en) begin
         case (state)
            S_SEND: begin
               tx_sr  <= {tx_sr[46:0], 1'b1};
               tx_cnt <= tx_cnt + 6'd1;
            end
            S_TURN: begin
               if (!cmd_pin_in) begin
                  // Start bit is response bit 0; a leading 0 leaves a zero CRC register unchanged.
                  rx_sr  <= rx_nxt[126:0];
                  rx_cnt <= 8'd1;
                  rx_crc <= '0;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
                  if (to_expire) err_timeout_q <= 1'b1;
               end
            end
            S_RECV: begin
               rx_sr  <= rx_nxt[126:0];
               rx_cnt <= rx_cnt + 8'd1;
               if (rx_covered) rx_crc <= crc7_step(rx_crc, cmd_pin_in);
               if (rx_last) begin
                  response_q  <= is_long ? {8'h00, rx_nxt[127:8]} : {96'h0, rx_nxt[39:8]};
                  err_end_q   <= ~rx_nxt[0];
                  err_crc_q   <= crc_en_q && (rx_nxt[7:1] != rx_crc);
                  err_index_q <= idx_en_q && !is_long && (rx_nxt[45:40] != idx_q);
               end
            end
            default: ;
         endcase
      end
   end

   assign host.busy        = busy_c;
   assign host.done        = done_c;
   assign host.response    = response_q;
   assign host.err_timeout = err_timeout_q;
   assign host.err_crc     = err_crc_q;
   assign host.err_end     = err_end_q;
   assign host.err_index   = err_index_q;

endmodule

// File: doc/cmd_phy.md
# cmd_phy

SD host command-line physical layer. It sits directly below the command control block and drives the shared CMD pin. The control block hands it a command index and argument, and this block serializes the 48-bit command frame with CRC7. It then turns the line around, waits for the card's start bit with a timeout, and deserializes a 48-bit or 136-bit response. Before handing the response up through a done/ack handshake, it checks the response's CRC7, end bit and index.

## Interface
Parameters:
- TIMEOUT_CYCLES, 64: number of bit-time strobes allowed between command end bit and response start bit.

Ports:
- clock  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-low reset.
- sd_clk_en  in  1  bit-time strobe (one `clock` cycle per SD clock period). All line activity advances only on cycles where this is 1.
- start  in  1  request pulse; accepted only in IDLE.
- cmd_index  in  6  command index; sampled at accept.
- cmd_argument  in  32  command argument; sampled at accept.
- response_type  in  2  00 none, 01 136-bit, 10 48-bit, 11 48-bit with busy (treated as 48-bit); sampled at accept.
- crc_check_en  in  1  enable response CRC7 check; sampled at accept.
- index_check_en  in  1  enable response index check; sampled at accept.
- cmd_pin_in  in  1  CMD line input.
- cmd_pin_out  out  1  CMD line output data.
- cmd_oe  out  1  CMD line output enable.
- response  out  128  captured response.
- busy  out  1  high from accept until done.
- done  out  1  command complete; held until `ack`.
- ack  in  1  clears `done`.
- err_timeout, err_crc, err_end, err_index  out  1 each  error flags; valid while `done` is high.

## Operation
- States and transitions:
  - IDLE → SEND on `start`.
  - SEND → TURN after the 48th bit. If response_type is 00, SEND → DONE instead.
  - TURN → RECV when a 0 is sampled. TURN → DONE (err_timeout) after TIMEOUT_CYCLES strobes with no 0 sampled.
  - RECV → DONE after the last bit.
  - DONE → IDLE on `ack`.
- Command frame, sent MSB first: {1'b0, 1'b1, cmd_index, cmd_argument, crc7, 1'b1}.
  - crc7 uses polynomial x^7+x^3+1, register initialised to 0, computed over the first 40 bits.
- SEND:
  - `cmd_oe`=1 throughout; `cmd_pin_out` shows the current bit.
  - The bit counter advances on each `sd_clk_en`.
  - After the end bit has been held through one strobe, `cmd_oe` drops to 0 and `cmd_pin_out` returns to 1.
- TURN:
  - `cmd_pin_in` is sampled on strobes only; the first strobe occurs after `cmd_oe` has dropped.
  - The sampled start bit counts as response bit 0.
- RECV:
  - Samples 47 further bits for a 48-bit response, or 135 further bits for a 136-bit response, into a shift register.
- Response mapping:
  - 48-bit: response[31:0] = R[39:8]; all other bits 0.
  - 136-bit: response[119:0] = R[127:8]; response[127:120] = 0.
- Checks, evaluated at entry to DONE:
  - err_end = (last bit == 0).
  - err_crc = crc_check_en && (received CRC7 != computed CRC7). For 48-bit the CRC covers R[47:8]; for 136-bit it covers R[127:8].
  - err_index = index_check_en && 48-bit && (R[45:40] != latched index). It is never set for 136-bit.
  - On timeout, only err_timeout is set; `response` is unchanged.
- Errors and `response` are cleared on accept of a new `start`.
- Ignored inputs:
  - `start` is ignored outside IDLE, including the DONE cycle in which `ack` is seen.
  - `ack` outside DONE is ignored.
- Reset, including mid-operation: state goes to IDLE immediately. Outputs take these values: cmd_oe=0, cmd_pin_out=1, busy=0, done=0, all errors 0, response=0.

## Timing
- Accept at edge T: `busy`, `cmd_oe` and start bit 0 are visible from T+1. Input values after T have no effect.
- Each frame bit holds until the next strobe edge. With `sd_clk_en` constantly 1, one bit is sent per `clock`.
- response_type 00:
  - `done` rises one cycle after the strobe that retires the end bit.
  - `busy` falls in the same cycle `done` rises.
- Response commands: `done` rises one cycle after the strobe that samples the last response bit.
- Timeout: `done` with err_timeout rises one cycle after the TIMEOUT_CYCLES-th strobe in TURN.
- `done`, `response` and the errors are stable until `ack`. `done` falls the cycle after `ack` is sampled.
- `sd_clk_en` held 0: the FSM freezes in place, except for the DONE/ack handshake.

## Test plan
- CMD0, argument 0, type 00, sd_clk_en=1 → serial output 0x40_00000000_95 MSB first; `done` after 48 bits; no errors; cmd_oe=0 at the end.
- CMD8, argument 0x1AA, type 10; card echoes 0x48_000001AA_87 after 5 idle bits → frame 0x48_000001AA_87 sent; response=0x000001AA; no errors.
- CMD8 with `cmd_pin_in` held 1 → err_timeout exactly 64 strobes into TURN; other errors 0.
- Echo with CRC byte 0x86 → err_crc=1 with crc_check_en=1; err_crc=0 with crc_check_en=0. Echo index 0x09 with index_check_en=1 → err_index=1. Last bit 0 → err_end=1.
- CMD2, type 01, 136-bit response with valid CRC → response[119:0]=R[127:8]; err_index=0 even with index_check_en=1.
- `start` during SEND is ignored. `done` stays high for 10 cycles without `ack`, then clears one cycle after `ack`. Asserting reset mid-SEND → cmd_oe=0, busy=0 immediately, and a following `start` runs normally. Strobe every 4th cycle → bit periods of 4 cycles.
